// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake/status bundle between a FIFO pointer controller and its user/storage.
// Parameterised by ADDR_W; DEPTH = 2**ADDR_W one-hot load lines.
interface fifo_ptr_ctrl_if #(
   parameter int ADDR_W = 4
);
   localparam int DEPTH = 1 << ADDR_W;

   logic              wr_req;
   logic              rd_req;
   logic [DEPTH-1:0]  wr_load;
   logic [ADDR_W-1:0] rd_sel;
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;
   logic              almost_full;
   logic              almost_empty;

   modport master (
      output wr_req, rd_req,
      input  wr_load, rd_sel, wr_ptr, rd_ptr, count, full, empty,
             overflow, underflow, almost_full, almost_empty
   );

   modport slave (
      input  wr_req, rd_req,
      output wr_load, rd_sel, wr_ptr, rd_ptr, count, full, empty,
             overflow, underflow, almost_full, almost_empty
   );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/flag controller for a 2**ADDR_W-entry register-bank FIFO; FIFO_ALMOST_FLAGS_EN adds almost flags.
// Latency: wr_load/rd_sel combinational (zero-latency write, show-ahead read); flags update the cycle after.
// Backpressure: writes refused while full, reads while empty; refusals set sticky overflow/underflow.
module fifo_ptr_ctrl #(
   parameter int ADDR_W = 4
`ifdef FIFO_ALMOST_FLAGS_EN
   ,
   parameter int AF_THRESH = 14,
   parameter int AE_THRESH = 2
`endif
) (
   input  logic           clk,
   input  logic           rst_n,
   fifo_ptr_ctrl_if.slave bus
);
   localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

   logic [ADDR_W:0] wr_ptr_q;
   logic [ADDR_W:0] rd_ptr_q;
   logic [ADDR_W:0] count_w;
   logic            full_w;
   logic            empty_w;
   logic            wr_acc;
   logic            rd_acc;
   logic            overflow_q;
   logic            underflow_q;

   assign count_w = wr_ptr_q - rd_ptr_q;
   assign empty_w = (wr_ptr_q == rd_ptr_q);
   assign full_w  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                    (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

   // rst_n gates acceptance so storage sees no load enable while reset is held
   assign wr_acc = bus.wr_req & ~full_w & rst_n;
   assign rd_acc = bus.rd_req & ~empty_w & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (rd_acc) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (bus.wr_req && full_w)  overflow_q  <= 1'b1;
         if (bus.rd_req && empty_w) underflow_q <= 1'b1;
      end
   end

   always_comb begin
      bus.wr_load = '0;
      if (wr_acc) bus.wr_load[wr_ptr_q[ADDR_W-1:0]] = 1'b1;
   end

   assign bus.rd_sel    = rd_ptr_q[ADDR_W-1:0];
   assign bus.wr_ptr    = wr_ptr_q;
   assign bus.rd_ptr    = rd_ptr_q;
   assign bus.count     = count_w;
   assign bus.full      = full_w;
   assign bus.empty     = empty_w;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

`ifdef FIFO_ALMOST_FLAGS_EN
   localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

   assign bus.almost_full  = (count_w >= AF_LVL);
   assign bus.almost_empty = (count_w <= AE_LVL);
`else
   assign bus.almost_full  = 1'b0;
   assign bus.almost_empty = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: reference pointer model plus a scoreboard of written slot indices.
module tb_fifo_ptr_ctrl;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int AF_LVL = 14;
   localparam int AE_LVL = 2;

   logic clk = 1'b0;
   logic rst_n;

   fifo_ptr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [4:0]  m_wr;
   logic [4:0]  m_rd;
   int          m_cnt;
   bit          m_ovf;
   bit          m_udf;
   logic [3:0]  sb_q[$];
   logic [15:0] obs_load;
   logic [15:0] exp_load;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic model_clear();
      m_wr  = '0;
      m_rd  = '0;
      m_cnt = 0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      sb_q.delete();
   endtask

   task automatic do_reset();
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock of stimulus; read-side scoreboard pops the slot the model says is at the head.
   task automatic step(input bit w, input bit r);
      bit         wacc;
      bit         racc;
      logic [3:0] exp_sel;
      @(negedge clk);
      bus.wr_req = w;
      bus.rd_req = r;
      #1;
      wacc     = w && (m_cnt < DEPTH);
      racc     = r && (m_cnt > 0);
      exp_load = wacc ? (16'h0001 << m_wr[3:0]) : 16'h0000;
      obs_load = bus.wr_load;
      if (racc && sb_q.size() > 0) begin
         exp_sel = sb_q.pop_front();
         n_chk++;
         if (bus.rd_sel !== exp_sel) begin
            n_fail++;
            $display("FAIL rd_sel: got %0d expected %0d", bus.rd_sel, exp_sel);
         end
      end
      if (wacc) sb_q.push_back(m_wr[3:0]);
      @(posedge clk);
      if (wacc) m_wr = m_wr + 5'd1;
      if (racc) m_rd = m_rd + 5'd1;
      m_cnt = m_cnt + int'(wacc) - int'(racc);
      if (w && !wacc) m_ovf = 1'b1;
      if (r && !racc) m_udf = 1'b1;
      #2;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
   endtask

   task automatic test_reset();
      bus.wr_req = 1'b1;
      bus.rd_req = 1'b0;
      rst_n      = 1'b0;
      model_clear();
      #12;
      n_chk++;
      if (bus.wr_ptr !== 5'd0 || bus.rd_ptr !== 5'd0 || bus.count !== 5'd0 || bus.empty !== 1'b1 ||
          bus.full !== 1'b0 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0 || bus.wr_load !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_state: wp=%0d rp=%0d cnt=%0d e=%b f=%b ov=%b un=%b load=%h expected 0 0 0 1 0 0 0 0000",
                  bus.wr_ptr, bus.rd_ptr, bus.count, bus.empty, bus.full, bus.overflow, bus.underflow, bus.wr_load);
      end
      @(negedge clk);
      bus.wr_req = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
      n_chk++;
      if (bus.count !== 5'd5) begin
         n_fail++;
         $display("FAIL pre_reset_count: got %0d expected 5", bus.count);
      end
      #1;
      bus.wr_req = 1'b1;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if (bus.wr_ptr !== 5'd0 || bus.rd_ptr !== 5'd0 || bus.count !== 5'd0 || bus.empty !== 1'b1 ||
          bus.full !== 1'b0 || bus.wr_load !== 16'h0) begin
         n_fail++;
         $display("FAIL midcycle_reset: wp=%0d rp=%0d cnt=%0d e=%b f=%b load=%h expected 0 0 0 1 0 0000",
                  bus.wr_ptr, bus.rd_ptr, bus.count, bus.empty, bus.full, bus.wr_load);
      end
      bus.wr_req = 1'b0;
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0);
         n_chk++;
         if (obs_load !== (16'h0001 << i)) begin
            n_fail++;
            $display("FAIL fill_load[%0d]: got %h expected %h", i, obs_load, 16'h0001 << i);
         end
      end
      n_chk++;
      if (bus.full !== 1'b1 || bus.count !== 5'd16 || bus.wr_ptr !== 5'b10000 || bus.empty !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_end: f=%b cnt=%0d wp=%b e=%b expected 1 16 10000 0",
                  bus.full, bus.count, bus.wr_ptr, bus.empty);
      end
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b0);
      n_chk++;
      if (obs_load !== 16'h0 || bus.wr_ptr !== 5'b10000 || bus.overflow !== 1'b1 || bus.count !== 5'd16) begin
         n_fail++;
         $display("FAIL overflow: load=%h wp=%b ov=%b cnt=%0d expected 0000 10000 1 16",
                  obs_load, bus.wr_ptr, bus.overflow, bus.count);
      end
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1);
      n_chk++;
      if (bus.empty !== 1'b1 || bus.count !== 5'd0 || bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_end: e=%b cnt=%0d ov=%b un=%b expected 1 0 1 0",
                  bus.empty, bus.count, bus.overflow, bus.underflow);
      end
      step(1'b0, 1'b1);
      n_chk++;
      if (bus.underflow !== 1'b1 || bus.rd_ptr !== 5'b10000 || bus.count !== 5'd0) begin
         n_fail++;
         $display("FAIL underflow: un=%b rp=%b cnt=%0d expected 1 10000 0", bus.underflow, bus.rd_ptr, bus.count);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      n_chk++;
      if (bus.count !== 5'd15 || bus.wr_ptr !== 5'b10000 || bus.rd_ptr !== 5'd1 || bus.overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_full: cnt=%0d wp=%b rp=%0d ov=%b expected 15 10000 1 1",
                  bus.count, bus.wr_ptr, bus.rd_ptr, bus.overflow);
      end
      do_reset();
      step(1'b1, 1'b1);
      n_chk++;
      if (bus.count !== 5'd1 || bus.rd_ptr !== 5'd0 || bus.wr_ptr !== 5'd1 || bus.underflow !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_empty: cnt=%0d rp=%0d wp=%0d un=%b expected 1 0 1 1",
                  bus.count, bus.rd_ptr, bus.wr_ptr, bus.underflow);
      end
   endtask

   task automatic test_wrap();
      bit exp_af;
      bit exp_ae;
      bit crossed;
      do_reset();
      crossed = 1'b0;
      // 14 writes to climb through both thresholds, then 26 paired ops push wr_ptr across 31 -> 0
      for (int i = 0; i < 40; i++) begin
         if (i < 14) step(1'b1, 1'b0);
         else        step(1'b1, 1'b1);
         if (m_wr == 5'd0) crossed = 1'b1;
`ifdef FIFO_ALMOST_FLAGS_EN
         exp_af = (m_cnt >= AF_LVL);
         exp_ae = (m_cnt <= AE_LVL);
`else
         exp_af = 1'b0;
         exp_ae = 1'b0;
`endif
         n_chk++;
         if (bus.count !== 5'(m_cnt) || bus.wr_ptr !== m_wr || bus.rd_ptr !== m_rd ||
             bus.almost_full !== exp_af || bus.almost_empty !== exp_ae) begin
            n_fail++;
            $display("FAIL wrap_op[%0d]: cnt=%0d wp=%0d rp=%0d af=%b ae=%b expected %0d %0d %0d %b %b",
                     i, bus.count, bus.wr_ptr, bus.rd_ptr, bus.almost_full, bus.almost_empty,
                     m_cnt, m_wr, m_rd, exp_af, exp_ae);
         end
      end
      n_chk++;
      if (!crossed || bus.wr_ptr !== 5'd8 || bus.count !== 5'd14) begin
         n_fail++;
         $display("FAIL wrap_end: wp=%0d cnt=%0d crossed=%b expected 8 14 1", bus.wr_ptr, bus.count, crossed);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_overflow();
      test_drain();
      test_simultaneous();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
